// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Optional feature macro used by keypad_scan: KEYPAD_AUTOREPEAT_EN.
package keypad_pkg;

   localparam int unsigned NROWS = 4;
   localparam int unsigned NCOLS = 4;

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      PRESSED,
      RELEASE
   } state_t;

   typedef enum logic [1:0] {
      NONE,
      SINGLE,
      MULTI
   } scan_res_t;

endpackage

// File: rtl/keypad_row_scan.sv
// Column synchronizer, row strobe ring and per-scan column capture/classification.
module keypad_row_scan
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic       scan_done,
   output logic [1:0] scan_result,
   output logic [3:0] scan_code
);

   localparam int unsigned CW = $clog2(SCAN_DIV);

   logic [3:0]    sync1;
   logic [3:0]    cs;
   logic [CW-1:0] cnt;
   logic [1:0]    ridx;
   logic [2:0][NCOLS-1:0] cap;
   logic [NROWS*NCOLS-1:0] hits;
   logic [4:0]    nhits;
   logic          tick;

   assign tick      = (cnt == CW'(SCAN_DIV - 1));
   assign scan_done = tick && (ridx == 2'd3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= '1;
         cs      <= '1;
         cnt     <= '0;
         ridx    <= '0;
         row_out <= 4'b1110;
         cap     <= '0;
      end else begin
         sync1 <= col_in;
         cs    <= sync1;
         if (tick) begin
            cnt     <= '0;
            ridx    <= ridx + 2'd1;
            row_out <= {row_out[2:0], row_out[3]};
            if (ridx != 2'd3)
               cap[ridx] <= ~cs;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // Row 3 is classified straight from the live sample so the result is ready on its tick.
   assign hits = {~cs, cap};

   always_comb begin
      nhits     = '0;
      scan_code = '0;
      for (int unsigned i = 0; i < NROWS*NCOLS; i++) begin
         if (hits[i]) begin
            nhits     = nhits + 5'd1;
            scan_code = 4'(i);
         end
      end
      if (nhits == 5'd0)
         scan_result = NONE;
      else if (nhits == 5'd1)
         scan_result = SINGLE;
      else
         scan_result = MULTI;
   end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner top: debounce FSM and key outputs over keypad_row_scan.
// Define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid every REPEAT_SCANS held scans.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 5000,
   parameter int unsigned DEBOUNCE_SCANS = 4,
   parameter int unsigned REPEAT_SCANS   = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   if (SCAN_DIV < 3 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1)
      $error("keypad_scan: SCAN_DIV>=3, DEBOUNCE_SCANS>=1, REPEAT_SCANS>=1 required");

   localparam int unsigned DW       = $clog2(DEBOUNCE_SCANS + 1);
   localparam bit          ONE_SCAN = (DEBOUNCE_SCANS == 1);

   logic          scan_done;
   logic [1:0]    scan_result;
   logic [3:0]    scan_code;
   scan_res_t     res;
   state_t        state;
   logic [3:0]    cand;
   logic [DW-1:0] dcnt;
   logic          dcnt_last;

   keypad_row_scan #(.SCAN_DIV(SCAN_DIV)) u_row_scan (
      .clk         (clk),
      .rst         (rst),
      .col_in      (col_in),
      .row_out     (row_out),
      .scan_done   (scan_done),
      .scan_result (scan_result),
      .scan_code   (scan_code)
   );

   assign res       = scan_res_t'(scan_result);
   assign dcnt_last = (dcnt == DW'(DEBOUNCE_SCANS - 1));

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int unsigned RW = $clog2(REPEAT_SCANS + 1);
   logic [RW-1:0] rcnt;
   logic          rep_last;
   assign rep_last = (rcnt == RW'(REPEAT_SCANS - 1));
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cand      <= '0;
         dcnt      <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rcnt      <= '0;
`endif
      end else begin
         key_valid <= 1'b0;
         if (scan_done) begin
            unique case (state)
               IDLE: begin
                  if (res == SINGLE) begin
                     cand <= scan_code;
                     dcnt <= DW'(1);
                     if (ONE_SCAN) begin
                        state     <= PRESSED;
                        key_code  <= scan_code;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                     end else begin
                        state <= DEBOUNCE;
                     end
                  end
               end
               DEBOUNCE: begin
                  if (res == SINGLE && scan_code == cand) begin
                     dcnt <= dcnt + DW'(1);
                     if (dcnt_last) begin
                        state     <= PRESSED;
                        key_code  <= cand;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                     end
                  end else begin
                     state <= IDLE;
                     dcnt  <= '0;
                  end
               end
               PRESSED: begin
                  if (res == NONE) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                     rcnt <= '0;
`endif
                     if (ONE_SCAN) begin
                        state    <= IDLE;
                        dcnt     <= '0;
                        key_held <= 1'b0;
                     end else begin
                        state <= RELEASE;
                        dcnt  <= DW'(1);
                     end
                  end
`ifdef KEYPAD_AUTOREPEAT_EN
                  else if (res == SINGLE && scan_code == cand) begin
                     if (rep_last) begin
                        rcnt      <= '0;
                        key_valid <= 1'b1;
                     end else begin
                        rcnt <= rcnt + RW'(1);
                     end
                  end
`endif
               end
               RELEASE: begin
                  if (res == NONE) begin
                     if (dcnt_last) begin
                        state    <= IDLE;
                        dcnt     <= '0;
                        key_held <= 1'b0;
                     end else begin
                        dcnt <= dcnt + DW'(1);
                     end
                  end else begin
                     state <= PRESSED;
                     dcnt  <= '0;
                  end
               end
            endcase
         end
      end
   end

endmodule
